// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : RISC-V instruction fetch stage with in-order imem requests,
//            a small instruction queue and opcode predecode for decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          DEPTH           = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic [2:0]  dec_imm_src
);

    localparam int                 c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_cnt_w = $clog2(DEPTH + 1);
    localparam int                 c_out_w = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(DEPTH - 1);

    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_rsp_pc;
    logic [31:0]        r_q_instr [DEPTH];
    logic [31:0]        r_q_pc    [DEPTH];
    logic [2:0]         r_q_imm   [DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;
    logic               r_not_empty;
    logic [c_out_w-1:0] r_inflight;
    logic [c_out_w-1:0] r_drop;

    logic               w_req_fire;
    logic               w_push;
    logic               w_pop;
    logic [2:0]         w_imm;
    logic [31:0]        w_occupancy;
    logic [31:0]        w_redirect_base;
    logic [c_cnt_w-1:0] w_count_nxt;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_last) ? '0 : p + c_ptr_w'(1);
    endfunction

    // Credit only live requests; stale ones never land in the queue.
    assign w_occupancy     = 32'(r_count) + 32'(r_inflight) - 32'(r_drop);
    assign imem_req_valid  = !rst && !redirect_valid
                             && (32'(r_inflight) < 32'(MAX_OUTSTANDING))
                             && (w_occupancy < 32'(DEPTH));
    assign imem_req_addr   = r_fetch_pc;
    assign w_req_fire      = imem_req_valid && imem_req_ready;
    assign w_push          = imem_rsp_valid && (r_drop == '0) && !redirect_valid;
    assign w_pop           = r_not_empty && dec_ready && !redirect_valid;
    assign w_redirect_base = redirect_pc & 32'hFFFF_FFFC;
    assign w_count_nxt     = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);

    always_comb begin
        w_imm = 3'b000;
        case (imem_rsp_data[6:0])
            7'b0100011:             w_imm = 3'b001;
            7'b1100011:             w_imm = 3'b010;
            7'b0110111, 7'b0010111: w_imm = 3'b011;
            7'b1101111:             w_imm = 3'b100;
            default:                w_imm = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc  <= RESET_PC;
            r_rsp_pc    <= RESET_PC;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_not_empty <= 1'b0;
            r_inflight  <= '0;
            r_drop      <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc  <= w_redirect_base;
            r_rsp_pc    <= w_redirect_base;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_not_empty <= 1'b0;
            // A response landing this cycle is already stale and retires now.
            r_inflight  <= r_inflight - c_out_w'(imem_rsp_valid);
            r_drop      <= r_inflight - c_out_w'(imem_rsp_valid);
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            r_inflight <= r_inflight + c_out_w'(w_req_fire) - c_out_w'(imem_rsp_valid);
            if (imem_rsp_valid && (r_drop != '0)) begin
                r_drop <= r_drop - c_out_w'(1);
            end
            if (w_push) begin
                r_tail   <= ptr_inc(r_tail);
                r_rsp_pc <= r_rsp_pc + 32'd4;
            end
            if (w_pop) begin
                r_head <= ptr_inc(r_head);
            end
            r_count     <= w_count_nxt;
            r_not_empty <= (w_count_nxt != '0);
        end
    end

    // Queue storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_tail] <= imem_rsp_data;
            r_q_pc[r_tail]    <= r_rsp_pc;
            r_q_imm[r_tail]   <= w_imm;
        end
    end

    assign dec_valid   = r_not_empty;
    assign dec_instr   = r_not_empty ? r_q_instr[r_head] : 32'h0;
    assign dec_pc      = r_not_empty ? r_q_pc[r_head]    : 32'h0;
    assign dec_imm_src = r_not_empty ? r_q_imm[r_head]   : 3'b000;

endmodule
`default_nettype wire
